// File: rtl/mcht_rx_dec.sv
// Manchester receive decoder: oversampled RXD, start/stop framing,
// mid-bit resync, parallel message out with valid/error strobes.
module mcht_rx_dec #(
    parameter int pMSG_LEN = 8,
    parameter int pOSR     = 8
) (
    input  logic                CLK100M,
    input  logic                RST_N,
    input  logic                RXD,
    input  logic                EN,
    output logic [pMSG_LEN-1:0] RX_MSG,
    output logic                RX_VLD,
    output logic                RX_ERR,
    output logic                RX_BUSY
);

    localparam int PW = $clog2(pOSR);
    localparam int IW = (pMSG_LEN > 1) ? $clog2(pMSG_LEN) : 1;

    localparam logic [PW-1:0] PH_A   = PW'(pOSR / 4);
    localparam logic [PW-1:0] PH_B   = PW'(3 * pOSR / 4);
    localparam logic [PW-1:0] PH_LO  = PW'(pOSR / 2 - 1);
    localparam logic [PW-1:0] PH_HI  = PW'(pOSR / 2 + 1);
    localparam logic [PW-1:0] PH_MAX = PW'(pOSR - 1);
    localparam logic [IW-1:0] LAST   = IW'(pMSG_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q;
    logic                  rxdp_q;
    logic [PW-1:0]         ph_q, ph_d;
    logic [IW-1:0]         bit_q, bit_d;
    logic                  a_q, a_d;
    logic [pMSG_LEN-1:0]   sh_q, sh_d;
    logic [pMSG_LEN-1:0]   msg_q, msg_d;
    logic                  vld_q, vld_d;
    logic                  err_q, err_d;

    logic rxd_s, edge_w, samp_a, samp_b, wrap, in_win;
    logic ok, bad, shift;

    assign rxd_s  = sync_q[1];
    assign edge_w = rxd_s ^ rxdp_q;
    assign samp_a = (ph_q == PH_A);
    assign samp_b = (ph_q == PH_B);
    assign wrap   = (ph_q == PH_MAX);
    assign in_win = (ph_q >= PH_LO) && (ph_q <= PH_HI);

    // Sync flops reset to the idle level so release never looks like a start.
    always_ff @(posedge CLK100M or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            rxdp_q  <= 1'b1;
            ph_q    <= '0;
            bit_q   <= '0;
            a_q     <= 1'b1;
            sh_q    <= '0;
            msg_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], RXD};
            rxdp_q  <= rxd_s;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            a_q     <= a_d;
            sh_q    <= sh_d;
            msg_q   <= msg_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = wrap ? '0 : ph_q + PW'(1);
        bit_d   = bit_q;
        ok      = 1'b0;
        bad     = 1'b0;
        shift   = 1'b0;
        // A mid-bit edge near the centre means this cycle is pOSR/2.
        if ((state_q == START || state_q == DATA) && edge_w && in_win)
            ph_d = PH_HI;
        case (state_q)
            IDLE: begin
                ph_d = '0;
                if (rxdp_q && !rxd_s) begin
                    state_d = START;
                    ph_d    = PW'(1);
                end
            end
            START: begin
                if (samp_a && rxd_s) begin
                    state_d = IDLE;
                end else if (samp_b && !rxd_s) begin
                    bad     = 1'b1;
                    state_d = IDLE;
                end else if (wrap) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (samp_b) begin
                    if (a_q == rxd_s) begin
                        bad     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        shift = 1'b1;
                    end
                end else if (wrap) begin
                    if (bit_q == LAST) state_d = STOP;
                    else bit_d = bit_q + IW'(1);
                end
            end
            STOP: begin
                if (samp_b) begin
                    state_d = IDLE;
                    if (a_q && rxd_s) ok = 1'b1;
                    else bad = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!EN) begin
            state_d = IDLE;
            ok      = 1'b0;
            bad     = 1'b0;
            shift   = 1'b0;
        end
    end

    always_comb begin
        a_d   = samp_a ? rxd_s : a_q;
        sh_d  = shift ? ((sh_q << 1) | pMSG_LEN'(rxd_s)) : sh_q;
        msg_d = ok ? sh_q : msg_q;
        vld_d = ok;
        err_d = bad;
    end

    assign RX_MSG  = msg_q;
    assign RX_VLD  = vld_q;
    assign RX_ERR  = err_q;
    assign RX_BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_mcht_rx_dec.sv
// Bench for mcht_rx_dec: Manchester frames built from line rules,
// outcomes predicted from frame content and compared by assertion.
module tb_mcht_rx_dec;

    localparam int M   = 8;
    localparam int OSR = 8;
    localparam int LAT = 2 + (M + 1) * OSR + 3 * OSR / 4 + 1;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         rxd   = 1'b1;
    logic         en    = 1'b1;
    logic [M-1:0] rx_msg;
    logic         rx_vld, rx_err, rx_busy;

    mcht_rx_dec #(.pMSG_LEN(M), .pOSR(OSR)) dut (
        .CLK100M(clk),
        .RST_N  (rst_n),
        .RXD    (rxd),
        .EN     (en),
        .RX_MSG (rx_msg),
        .RX_VLD (rx_vld),
        .RX_ERR (rx_err),
        .RX_BUSY(rx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int vld_n = 0, err_n = 0, both_n = 0, chg_n = 0;
    int vld_cyc = 0;
    int t0 = 0;
    logic [M-1:0] got[$];
    logic [M-1:0] prev_msg = '0;
    logic         prev_rst = 1'b0;
    logic [M-1:0] exp_msg = '0;
    logic         lv[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_vld) begin
            vld_n++;
            vld_cyc = cyc;
            got.push_back(rx_msg);
        end
        if (rx_err) err_n++;
        if (rx_vld && rx_err) both_n++;
        if (rst_n && prev_rst && !rx_vld && rx_msg !== prev_msg) chg_n++;
        prev_msg = rx_msg;
        prev_rst = rst_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_lvl(input logic l, input int n);
        repeat (n) lv.push_back(l);
    endtask

    // Line image: start bit '1', data MSB first, stop high; a bad bit is
    // held flat for a whole period and the line then goes idle.
    task automatic build(input logic [M-1:0] d, input int bl, input int bad,
                         input logic bad_lvl);
        int h;
        logic b;
        h = bl / 2;
        lv.delete();
        push_lvl(1'b0, h);
        push_lvl(1'b1, bl - h);
        for (int i = 0; i < M; i++) begin
            b = d[M-1-i];
            if (i == bad) begin
                push_lvl(bad_lvl, bl);
                return;
            end
            push_lvl(!b, h);
            push_lvl(b, bl - h);
        end
        push_lvl(1'b1, bl);
    endtask

    task automatic play(input int from, input int to);
        for (int i = from; i < to; i++) begin
            @(posedge clk);
            #1;
            rxd = lv[i];
            if (i == 0) t0 = cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rxd = 1'b1;
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic run_ok(input logic [M-1:0] d, input int bl);
        int v0, e0;
        v0 = vld_n;
        e0 = err_n;
        build(d, bl, -1, 1'b1);
        play(0, lv.size());
        idle(20);
        chk("ok_vld_cnt", 32'(vld_n - v0), 32'd1);
        chk("ok_err_cnt", 32'(err_n - e0), 32'd0);
        chk("ok_msg", 32'(rx_msg), 32'(d));
        if (bl == OSR) chk("ok_latency", 32'(vld_cyc - t0), 32'(LAT));
        exp_msg = d;
    endtask

    task automatic run_bad(input logic [M-1:0] d, input int bad,
                           input logic lvl);
        int v0, e0;
        v0 = vld_n;
        e0 = err_n;
        build(d, OSR, bad, lvl);
        play(0, lv.size());
        idle(20);
        chk("bad_err_cnt", 32'(err_n - e0), 32'd1);
        chk("bad_vld_cnt", 32'(vld_n - v0), 32'd0);
        chk("bad_msg_held", 32'(rx_msg), 32'(exp_msg));
    endtask

    initial begin
        int v0, e0, g0, ab;
        logic [M-1:0] d;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_msg", 32'(rx_msg), 32'd0);
        chk("rst_vld", 32'(rx_vld), 32'd0);
        chk("rst_err", 32'(rx_err), 32'd0);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        rst_n = 1'b1;
        idle(6);
        chk("rel_busy", 32'(rx_busy), 32'd0);

        run_ok(8'hA5, OSR);

        v0 = vld_n;
        build(8'h00, OSR, -1, 1'b1);
        play(0, lv.size());
        idle(OSR);
        build(8'hFF, OSR, -1, 1'b1);
        play(0, lv.size());
        idle(20);
        chk("b2b_vld_cnt", 32'(vld_n - v0), 32'd2);
        chk("b2b_first", 32'(got[got.size()-2]), 32'h00);
        chk("b2b_second", 32'(got[got.size()-1]), 32'hFF);
        chk("b2b_latency", 32'(vld_cyc - t0), 32'(LAT));
        exp_msg = 8'hFF;

        for (int w = 1; w <= 2; w++) begin
            v0 = vld_n;
            e0 = err_n;
            @(posedge clk);
            #1;
            rxd = 1'b0;
            g0 = cyc;
            repeat (w) begin
                @(posedge clk);
                #1;
            end
            rxd = 1'b1;
            wait_cyc(g0 + 3);
            chk("glitch_busy_hi", 32'(rx_busy), 32'd1);
            wait_cyc(g0 + 2 + OSR / 4 + 1);
            chk("glitch_busy_lo", 32'(rx_busy), 32'd0);
            idle(20);
            chk("glitch_vld", 32'(vld_n - v0), 32'd0);
            chk("glitch_err", 32'(err_n - e0), 32'd0);
        end

        run_bad(8'h3C, 3, 1'b1);
        run_ok(8'h12, OSR);

        run_ok(8'hC3, 7);
        run_ok(8'h5A, OSR);
        run_ok(8'hC3, 9);

        v0 = vld_n;
        e0 = err_n;
        build(8'h77, OSR, -1, 1'b1);
        play(0, (1 + 4) * OSR);
        @(posedge clk);
        #1;
        rxd = lv[(1 + 4) * OSR];
        en = 1'b0;
        @(negedge clk);
        chk("en_busy_before", 32'(rx_busy), 32'd1);
        @(negedge clk);
        chk("en_busy_after", 32'(rx_busy), 32'd0);
        chk("en_msg_held", 32'(rx_msg), 32'(exp_msg));
        play((1 + 4) * OSR + 1, lv.size());
        idle(4);
        en = 1'b1;
        idle(20);
        chk("en_vld", 32'(vld_n - v0), 32'd0);
        chk("en_err", 32'(err_n - e0), 32'd0);
        chk("en_msg_end", 32'(rx_msg), 32'(exp_msg));
        run_ok(8'h55, OSR);

        v0 = vld_n;
        e0 = err_n;
        build(8'h3A, OSR, -1, 1'b1);
        play(0, 4 * OSR + 3);
        chk("rst_mid_busy", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        rxd = 1'b1;
        #1;
        chk("rst_mid_msg", 32'(rx_msg), 32'd0);
        chk("rst_mid_vld", 32'(rx_vld), 32'd0);
        chk("rst_mid_err", 32'(rx_err), 32'd0);
        chk("rst_mid_busy0", 32'(rx_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_msg = '0;
        idle(20);
        chk("rst_mid_vld_cnt", 32'(vld_n - v0), 32'd0);
        chk("rst_mid_err_cnt", 32'(err_n - e0), 32'd0);
        run_ok(8'h55, OSR);

        for (int n = 0; n < 16; n++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                ab = int'($urandom_range(0, M - 1));
                run_bad(d, ab, 1'($urandom_range(0, 1)));
            end else begin
                run_ok(d, OSR);
            end
        end

        chk("vld_err_overlap", 32'(both_n), 32'd0);
        chk("msg_stable", 32'(chg_n), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
